// File: rtl/spsram_rr_arb_pkg.sv
// Shared types and width helpers for the round-robin single-port SRAM arbiter.
package spsram_rr_arb_pkg;

    // Wide enough for the largest legal requester count (16).
    localparam int TAG_IDW = 4;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               vld;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/spsram_rr_arb_rr_pick.sv
// Round-robin pick: lowest set request at or above ptr, wrapping to the bottom.
module spsram_rr_arb_rr_pick
    import spsram_rr_arb_pkg::*;
#(
    parameter int REQ_N = 4,
    parameter int IDW   = idx_w(REQ_N)
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [REQ_N-1:0] gnt,
    output logic [IDW-1:0]   gnt_id
);

    logic [2*REQ_N-1:0] dbl;
    logic               found;

    // Lower copy masked below ptr, upper copy intact: first hit is the wrapped winner.
    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < REQ_N; i++) begin
            if (i < int'(ptr)) dbl[i] = 1'b0;
        end
        found  = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < 2*REQ_N; i++) begin
            if (!found && dbl[i]) begin
                found  = 1'b1;
                gnt_id = IDW'(i % REQ_N);
            end
        end
        gnt = '0;
        if (found) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/spsram_rr_arb.sv
// Round-robin arbiter sharing one latency-pipelined single-port SRAM between
// REQ_N requesters, returning read data as a one-hot response LATENCY_N cycles later.
module spsram_rr_arb
    import spsram_rr_arb_pkg::*;
#(
    parameter int W         = 32,
    parameter int N         = 128,
    parameter int LATENCY_N = 1,
    parameter int REQ_N     = 4,
    localparam int AW       = idx_w(N),
    localparam int IDW      = idx_w(REQ_N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REQ_N-1:0]    req_vld,
    input  logic [REQ_N-1:0]    req_wen,
    input  logic [REQ_N*AW-1:0] req_addr,
    input  logic [REQ_N*W-1:0]  req_din,
    output logic [REQ_N-1:0]    req_rdy,
    output logic [REQ_N-1:0]    rsp_vld_r,
    output logic [W-1:0]        rsp_dout,
    output logic                sram_en,
    output logic                sram_wen,
    output logic [AW-1:0]       sram_addr,
    output logic [W-1:0]        sram_din,
    input  logic [W-1:0]        sram_dout_r,
    output logic                busy_r
);

    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gnt_id;
    logic [REQ_N-1:0]     gnt;
    logic [LATENCY_N-1:0] tag_vld;
    tag_t                 tag_last;

    spsram_rr_arb_rr_pick #(
        .REQ_N (REQ_N),
        .IDW   (IDW)
    ) u_pick (
        .req    (req_vld),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_rdy = gnt;

    // gnt_id is 0 when idle, so addr/din stay defined.
    always_comb begin
        sram_en   = |gnt;
        sram_wen  = sram_en & req_wen[gnt_id];
        sram_addr = req_addr[int'(gnt_id)*AW +: AW];
        sram_din  = req_din[int'(gnt_id)*W +: W];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (sram_en) ptr_d = (gnt_id == IDW'(REQ_N-1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // Requester-ID pipe running in lockstep with the SRAM read pipeline.
    for (genvar k = 0; k < LATENCY_N; k++) begin : g_tag
        tag_t tag_d, tag_q;
        if (k == 0) begin : g_head
            always_comb begin
                tag_d.vld = sram_en & ~sram_wen;
                tag_d.id  = TAG_IDW'(gnt_id);
            end
        end else begin : g_body
            always_comb tag_d = g_tag[k-1].tag_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) tag_q <= '0;
            else     tag_q <= tag_d;
        end
        assign tag_vld[k] = tag_q.vld;
    end

    assign tag_last = g_tag[LATENCY_N-1].tag_q;

    always_comb begin
        rsp_vld_r = '0;
        for (int k = 0; k < REQ_N; k++) begin
            rsp_vld_r[k] = tag_last.vld && (tag_last.id == TAG_IDW'(k));
        end
    end

    assign rsp_dout = sram_dout_r;
    assign busy_r   = |tag_vld;

endmodule
